bira_fault_collector: RTL and testbench
=======================================

Name: bira_fault_collector

Overview:
- Sits directly downstream of the MBIST engine and consumes its per-cycle fault report: bank, row, col and 8-bit column flag.
- Merges repeat reports of the same word and stores unique faulty words in a small CAM-style table.
- After the test ends, drains the table in allocation order over a valid/ready stream to the repair-allocation stage.
- Flags overflow when unique faults exceed table capacity; such a die is unrepairable.

Parameters:
ENTRIES, 16, number of unique faulty-word entries held
DRAIN_DELAY, 2, cycles to keep collecting after test_end rises (covers the BIST read-to-flag pipeline)
CNT_W, 5, width of fault_count; must satisfy 2^CNT_W > ENTRIES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
test  in  1  test mode request, same signal that drives the BIST
early_term  in  1  abort; synchronous clear back to IDLE
test_end  in  1  BIST termination indicator
fault_detect  in  1  fault report valid for this cycle
fault_bank  in  2  faulty bank address
fault_row  in  10  faulty row address
fault_col  in  10  faulty col address
fault_col_flag  in  8  faulty bit positions within the word
out_valid  out  1  drained entry valid
out_ready  in  1  downstream accepts entry
out_bank  out  2  entry bank
out_row  out  10  entry row
out_col  out  10  entry col
out_flag  out  8  merged bit-fault flag (OR of all reports)
out_last  out  1  current entry is the final one
busy  out  1  high in COLLECT and DRAIN
collect_done  out  1  high in DONE
fault_count  out  CNT_W  number of valid entries
overflow  out  1  a unique fault was dropped because the table was full

Behaviour:
- Reset (async, rst=1): state=IDLE; all entry valid bits cleared; every output 0.
- States: IDLE, COLLECT, HOLDOFF, DRAIN, DONE.
- IDLE -> COLLECT when test=1. Entering COLLECT clears the table, fault_count and overflow.
- Report acceptance (COLLECT and HOLDOFF): a report is taken when fault_detect=1 and fault_col_flag!=0; fault_detect with a zero flag is ignored.
- Match rule: an entry matches when it is valid and its {bank,row,col} equals the report. On a match, the entry flag is ORed with fault_col_flag.
- No match, count<ENTRIES: write the report into entry[fault_count] and increment fault_count the next cycle.
- No match, count==ENTRIES: drop the report and set overflow (sticky until the next COLLECT entry).
- One report is processed per cycle with no stall; the table is updated at the next clock edge.
- COLLECT -> HOLDOFF on the first cycle with test_end=1. A report in that same cycle is still accepted.
- HOLDOFF: accepts reports for exactly DRAIN_DELAY cycles, then -> DRAIN.
- DRAIN with fault_count==0: -> DONE directly; out_valid never asserts.
- DRAIN stream:
  - out_* present entry[rd_ptr], starting at rd_ptr=0.
  - out_valid stays high and out_* stay stable until out_valid&&out_ready.
  - out_last=1 when rd_ptr==fault_count-1.
  - A handshake on out_last -> DONE the next cycle, with out_valid=0.
- DONE: collect_done=1. fault_count and overflow hold. DONE -> IDLE when test=0.
- early_term=1 in any state: -> IDLE next cycle, table cleared, out_valid=0. Takes priority over all other events.
- test falling in COLLECT, HOLDOFF or DRAIN: -> IDLE, table cleared.
- busy = (state==COLLECT or HOLDOFF or DRAIN).

Optional Feature:
- Macro: BIRA_BITCOUNT_EN.
- Defined:
  - Adds output total_fault_bits, 12 bits, reset 0, cleared on COLLECT entry.
  - On each accepted report, adds the popcount of (fault_col_flag & ~existing_flag), or the full popcount for a new entry.
  - Adds nothing for reports dropped on overflow.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Three distinct reports (bank1/row5/col8/flag 0x01, bank1/row5/col16/0x80, bank2/row0/col0/0xFF), then test_end, out_ready=1 -> 3 beats in that order, out_last on the 3rd, fault_count=3, overflow=0, collect_done=1.
- Same address reported twice (flags 0x03 then 0x30) -> single entry, out_flag=0x33, fault_count=1; with BIRA_BITCOUNT_EN, total_fault_bits=4.
- 17 unique reports with ENTRIES=16 -> fault_count=16, overflow=1, 16 beats drained, 17th report absent.
- Report 2 cycles after test_end (DRAIN_DELAY=2) -> captured; report 3 cycles after -> ignored.
- out_ready toggled 1/0 per cycle during drain -> out_* stable while stalled, no beat lost or duplicated.
- early_term pulse mid-DRAIN after 1 beat -> out_valid=0 next cycle, state IDLE, fault_count=0, busy=0.

Source files
------------

// File: rtl/bira_fault_collector.sv
// BIRA fault collector: merges per-cycle MBIST fault reports into a small CAM-style table and drains it in allocation order.
// Optional feature BIRA_BITCOUNT_EN adds total_fault_bits, the running count of distinct faulty bit positions.

module bira_fault_collector #(
   parameter int ENTRIES     = 16,
   parameter int DRAIN_DELAY = 2,
   parameter int CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             test,
   input  logic             early_term,
   input  logic             test_end,
   input  logic             fault_detect,
   input  logic [1:0]       fault_bank,
   input  logic [9:0]       fault_row,
   input  logic [9:0]       fault_col,
   input  logic [7:0]       fault_col_flag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_bank,
   output logic [9:0]       out_row,
   output logic [9:0]       out_col,
   output logic [7:0]       out_flag,
   output logic             out_last,
   output logic             busy,
   output logic             collect_done,
   output logic [CNT_W-1:0] fault_count,
   output logic             overflow
`ifdef BIRA_BITCOUNT_EN
   ,output logic [11:0]     total_fault_bits
`endif
);

   localparam int HOLD_W = (DRAIN_DELAY > 1) ? $clog2(DRAIN_DELAY) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DRAIN_DELAY - 1);

   typedef enum logic [2:0] {IDLE, COLLECT, HOLDOFF, DRAIN, DONE} state_e;

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
   logic [CNT_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   faultCount_q, faultCount_d;
   logic               overflow_q, overflow_d;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [1:0]         bank_q [ENTRIES];
   logic [1:0]         bank_d [ENTRIES];
   logic [9:0]         row_q  [ENTRIES];
   logic [9:0]         row_d  [ENTRIES];
   logic [9:0]         col_q  [ENTRIES];
   logic [9:0]         col_d  [ENTRIES];
   logic [7:0]         flag_q [ENTRIES];
   logic [7:0]         flag_d [ENTRIES];

   logic [ENTRIES-1:0] hitVec;
   logic               anyHit;
   logic               tableFull;
   logic               tableClear;
   logic               accept;
   logic               drainValid;
   logic               drainLast;
   logic               handshake;
   logic [1:0]         rdBank;
   logic [9:0]         rdRow;
   logic [9:0]         rdCol;
   logic [7:0]         rdFlag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort beats everything; a falling test request abandons any in-flight collection or drain.
   always_comb begin
      state_d = state_q;
      if (early_term) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (test) state_d = COLLECT;
            COLLECT: begin
               if (!test)         state_d = IDLE;
               else if (test_end) state_d = HOLDOFF;
            end
            HOLDOFF: begin
               if (!test)                       state_d = IDLE;
               else if (holdCnt_q == HOLD_LAST) state_d = DRAIN;
            end
            DRAIN: begin
               if (!test)                        state_d = IDLE;
               else if (faultCount_q == '0)      state_d = DONE;
               else if (handshake && drainLast)  state_d = DONE;
            end
            DONE:    if (!test) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = (state_q == COLLECT) || (state_q == HOLDOFF) || (state_q == DRAIN);
      collect_done = (state_q == DONE);
      out_valid    = drainValid;
      out_last     = drainLast;
      out_bank     = drainValid ? rdBank : '0;
      out_row      = drainValid ? rdRow  : '0;
      out_col      = drainValid ? rdCol  : '0;
      out_flag     = drainValid ? rdFlag : '0;
      fault_count  = faultCount_q;
      overflow     = overflow_q;
   end

   // Reports are compared against the registered table only; one report lands per edge, so no bypass is needed.
   always_comb begin
      hitVec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hitVec[i] = valid_q[i] && (bank_q[i] == fault_bank) &&
                     (row_q[i] == fault_row) && (col_q[i] == fault_col);
      end
      anyHit     = |hitVec;
      tableFull  = (faultCount_q >= CNT_W'(ENTRIES));
      tableClear = early_term || ((state_q == IDLE) && test) ||
                   (!test && ((state_q == COLLECT) || (state_q == HOLDOFF) || (state_q == DRAIN)));
      accept     = !tableClear && ((state_q == COLLECT) || (state_q == HOLDOFF)) &&
                   fault_detect && (fault_col_flag != 8'h00);
   end

   always_comb begin
      valid_d      = valid_q;
      bank_d       = bank_q;
      row_d        = row_q;
      col_d        = col_q;
      flag_d       = flag_q;
      faultCount_d = faultCount_q;
      overflow_d   = overflow_q;
      if (tableClear) begin
         valid_d      = '0;
         faultCount_d = '0;
         overflow_d   = 1'b0;
      end else if (accept) begin
         if (anyHit) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (hitVec[i]) flag_d[i] = flag_q[i] | fault_col_flag;
            end
         end else if (!tableFull) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (CNT_W'(i) == faultCount_q) begin
                  valid_d[i] = 1'b1;
                  bank_d[i]  = fault_bank;
                  row_d[i]   = fault_row;
                  col_d[i]   = fault_col;
                  flag_d[i]  = fault_col_flag;
               end
            end
            faultCount_d = faultCount_q + 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_comb begin
      rdBank = '0;
      rdRow  = '0;
      rdCol  = '0;
      rdFlag = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (CNT_W'(i) == rdPtr_q) begin
            rdBank = bank_q[i];
            rdRow  = row_q[i];
            rdCol  = col_q[i];
            rdFlag = flag_q[i];
         end
      end
      drainValid = (state_q == DRAIN) && (faultCount_q != '0);
      drainLast  = drainValid && (rdPtr_q == (faultCount_q - 1'b1));
      handshake  = drainValid && out_ready;
      holdCnt_d  = (state_q == HOLDOFF) ? holdCnt_q + 1'b1 : '0;
      if (state_q == DRAIN) begin
         rdPtr_d = handshake ? rdPtr_q + 1'b1 : rdPtr_q;
      end else begin
         rdPtr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdCnt_q    <= '0;
         rdPtr_q      <= '0;
         faultCount_q <= '0;
         overflow_q   <= 1'b0;
         valid_q      <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            bank_q[i] <= '0;
            row_q[i]  <= '0;
            col_q[i]  <= '0;
            flag_q[i] <= '0;
         end
      end else begin
         holdCnt_q    <= holdCnt_d;
         rdPtr_q      <= rdPtr_d;
         faultCount_q <= faultCount_d;
         overflow_q   <= overflow_d;
         valid_q      <= valid_d;
         bank_q       <= bank_d;
         row_q        <= row_d;
         col_q        <= col_d;
         flag_q       <= flag_d;
      end
   end

`ifdef BIRA_BITCOUNT_EN
   logic [7:0]  matchFlag;
   logic [7:0]  newBits;
   logic [11:0] totalBits_q, totalBits_d;

   function automatic logic [3:0] popCount(input logic [7:0] bits);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) cnt = cnt + 4'(bits[i]);
      return cnt;
   endfunction

   // A new entry has no prior flag, so the same masked popcount covers both merge and allocate.
   always_comb begin
      matchFlag = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (hitVec[i]) matchFlag = matchFlag | flag_q[i];
      end
      newBits     = fault_col_flag & ~matchFlag;
      totalBits_d = totalBits_q;
      if (tableClear) begin
         totalBits_d = '0;
      end else if (accept && (anyHit || !tableFull)) begin
         totalBits_d = totalBits_q + 12'(popCount(newBits));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         totalBits_q <= '0;
      end else begin
         totalBits_q <= totalBits_d;
      end
   end

   assign total_fault_bits = totalBits_q;
`endif

endmodule

// File: tb/tb_bira_fault_collector.sv
// Scoreboard bench for bira_fault_collector: directed reports push expected drain beats, a negedge monitor checks them.
// Define BIRA_BITCOUNT_EN to also check total_fault_bits.

module tb_bira_fault_collector;

   typedef struct packed {
      logic [1:0] bank;
      logic [9:0] row;
      logic [9:0] col;
      logic [7:0] flag;
      logic       last;
   } beat_t;

   logic       clk;
   logic       rst;
   logic       test;
   logic       early_term;
   logic       test_end;
   logic       fault_detect;
   logic [1:0] fault_bank;
   logic [9:0] fault_row;
   logic [9:0] fault_col;
   logic [7:0] fault_col_flag;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_bank;
   logic [9:0] out_row;
   logic [9:0] out_col;
   logic [7:0] out_flag;
   logic       out_last;
   logic       busy;
   logic       collect_done;
   logic [4:0] fault_count;
   logic       overflow;
`ifdef BIRA_BITCOUNT_EN
   logic [11:0] totalFaultBits;
`endif

   int    checkCount = 0;
   int    failCount  = 0;
   beat_t expQ[$];

   bira_fault_collector dut (
      .clk            (clk),
      .rst            (rst),
      .test           (test),
      .early_term     (early_term),
      .test_end       (test_end),
      .fault_detect   (fault_detect),
      .fault_bank     (fault_bank),
      .fault_row      (fault_row),
      .fault_col      (fault_col),
      .fault_col_flag (fault_col_flag),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_bank       (out_bank),
      .out_row        (out_row),
      .out_col        (out_col),
      .out_flag       (out_flag),
      .out_last       (out_last),
      .busy           (busy),
      .collect_done   (collect_done),
      .fault_count    (fault_count),
`ifdef BIRA_BITCOUNT_EN
      .total_fault_bits (totalFaultBits),
`endif
      .overflow       (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c, input logic [7:0] f);
      fault_detect   = 1'b1;
      fault_bank     = b;
      fault_row      = r;
      fault_col      = c;
      fault_col_flag = f;
      tick();
      fault_detect   = 1'b0;
      fault_col_flag = 8'h00;
   endtask

   task automatic pushBeat(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c, input logic [7:0] f, input logic l);
      beat_t e;
      e.bank = b;
      e.row  = r;
      e.col  = c;
      e.flag = f;
      e.last = l;
      expQ.push_back(e);
   endtask

   task automatic startTest();
      test = 1'b1;
      tick();
   endtask

   task automatic endTest();
      test_end = 1'b1;
      tick();
      test_end = 1'b0;
   endtask

   task automatic waitDone(input bit toggle);
      int cycles = 0;
      while (!collect_done && cycles < 300) begin
         if (toggle) out_ready = ~out_ready;
         tick();
         cycles++;
      end
      checkOutput("done_reached", 32'(collect_done), 32'd1);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
   endtask

   task automatic leaveTest();
      test = 1'b0;
      tick();
      checkOutput("idle_after_done", 32'({busy, collect_done}), 32'd0);
   endtask

   // Every presented beat must equal the oldest outstanding expectation, including repeated stall cycles.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL unexpected_beat actual=%0h required=none",
                     {out_bank, out_row, out_col, out_flag, out_last});
         end else begin
            checkOutput("beat", 32'({out_bank, out_row, out_col, out_flag, out_last}), 32'(expQ[0]));
            if (out_ready) void'(expQ.pop_front());
         end
      end
   end

   initial begin
      rst            = 1'b1;
      test           = 1'b0;
      early_term     = 1'b0;
      test_end       = 1'b0;
      fault_detect   = 1'b0;
      fault_bank     = '0;
      fault_row      = '0;
      fault_col      = '0;
      fault_col_flag = '0;
      out_ready      = 1'b0;
      #12;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_status", 32'({busy, collect_done, overflow, out_last}), 32'd0);
      checkOutput("reset_fault_count", 32'(fault_count), 32'd0);
      rst = 1'b0;
      tick();

      // three distinct reports drained in allocation order
      startTest();
      applyStimulus(2'd1, 10'd5, 10'd8,  8'h01); pushBeat(2'd1, 10'd5, 10'd8,  8'h01, 1'b0);
      applyStimulus(2'd1, 10'd5, 10'd16, 8'h80); pushBeat(2'd1, 10'd5, 10'd16, 8'h80, 1'b0);
      applyStimulus(2'd2, 10'd0, 10'd0,  8'hFF); pushBeat(2'd2, 10'd0, 10'd0,  8'hFF, 1'b1);
      checkOutput("busy_collect", 32'(busy), 32'd1);
      out_ready = 1'b1;
      endTest();
      waitDone(1'b0);
      checkOutput("t1_fault_count", 32'(fault_count), 32'd3);
      checkOutput("t1_overflow", 32'(overflow), 32'd0);
      checkOutput("t1_busy_done", 32'(busy), 32'd0);
      leaveTest();

      // repeated address merges; zero-flag report ignored
      startTest();
      applyStimulus(2'd3, 10'd100, 10'd200, 8'h03);
      applyStimulus(2'd3, 10'd100, 10'd200, 8'h30);
      applyStimulus(2'd3, 10'd100, 10'd200, 8'h31);
      applyStimulus(2'd0, 10'd1, 10'd1, 8'h00);
      pushBeat(2'd3, 10'd100, 10'd200, 8'h33, 1'b1);
      endTest();
      waitDone(1'b0);
      checkOutput("t2_fault_count", 32'(fault_count), 32'd1);
      checkOutput("t2_overflow", 32'(overflow), 32'd0);
`ifdef BIRA_BITCOUNT_EN
      checkOutput("t2_total_bits", 32'(totalFaultBits), 32'd4);
`endif
      leaveTest();

      // 17 unique reports into a 16-entry table
      startTest();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(2'(i % 4), 10'(i + 1), 10'(3 * i), 8'(1 << (i % 8)));
         if (i < 16) pushBeat(2'(i % 4), 10'(i + 1), 10'(3 * i), 8'(1 << (i % 8)), i == 15);
      end
      checkOutput("t3_overflow_live", 32'(overflow), 32'd1);
      endTest();
      waitDone(1'b0);
      checkOutput("t3_fault_count", 32'(fault_count), 32'd16);
      checkOutput("t3_overflow", 32'(overflow), 32'd1);
`ifdef BIRA_BITCOUNT_EN
      checkOutput("t3_total_bits", 32'(totalFaultBits), 32'd16);
`endif
      leaveTest();

      // reports around test_end: same cycle and +2 captured, +3 ignored
      startTest();
      applyStimulus(2'd1, 10'd1, 10'd1, 8'h01); pushBeat(2'd1, 10'd1, 10'd1, 8'h01, 1'b0);
      test_end = 1'b1;
      applyStimulus(2'd1, 10'd2, 10'd2, 8'h02); pushBeat(2'd1, 10'd2, 10'd2, 8'h02, 1'b0);
      test_end = 1'b0;
      tick();
      applyStimulus(2'd1, 10'd3, 10'd3, 8'h04); pushBeat(2'd1, 10'd3, 10'd3, 8'h04, 1'b1);
      applyStimulus(2'd1, 10'd4, 10'd4, 8'h08);
      waitDone(1'b0);
      checkOutput("t4_fault_count", 32'(fault_count), 32'd3);
      leaveTest();

      // out_ready toggling every cycle during drain
      out_ready = 1'b0;
      startTest();
      applyStimulus(2'd0, 10'd10, 10'd20, 8'h11); pushBeat(2'd0, 10'd10, 10'd20, 8'h11, 1'b0);
      applyStimulus(2'd1, 10'd11, 10'd21, 8'h22); pushBeat(2'd1, 10'd11, 10'd21, 8'h22, 1'b0);
      applyStimulus(2'd2, 10'd12, 10'd22, 8'h44); pushBeat(2'd2, 10'd12, 10'd22, 8'h44, 1'b0);
      applyStimulus(2'd3, 10'd13, 10'd23, 8'h88); pushBeat(2'd3, 10'd13, 10'd23, 8'h88, 1'b1);
      endTest();
      waitDone(1'b1);
      checkOutput("t5_fault_count", 32'(fault_count), 32'd4);
      leaveTest();

      // early_term after the first beat of a drain
      out_ready = 1'b0;
      startTest();
      applyStimulus(2'd0, 10'd7, 10'd7, 8'h01); pushBeat(2'd0, 10'd7, 10'd7, 8'h01, 1'b0);
      applyStimulus(2'd0, 10'd8, 10'd8, 8'h02); pushBeat(2'd0, 10'd8, 10'd8, 8'h02, 1'b0);
      applyStimulus(2'd0, 10'd9, 10'd9, 8'h04); pushBeat(2'd0, 10'd9, 10'd9, 8'h04, 1'b1);
      endTest();
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         tick();
      end
      checkOutput("t6_drain_started", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready  = 1'b0;
      early_term = 1'b1;
      tick();
      early_term = 1'b0;
      checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_fault_count", 32'(fault_count), 32'd0);
      checkOutput("t6_collect_done", 32'(collect_done), 32'd0);
      test = 1'b0;
      expQ.delete();
      tick();

      // empty table goes straight to DONE
      out_ready = 1'b1;
      startTest();
      endTest();
      waitDone(1'b0);
      checkOutput("t7_fault_count", 32'(fault_count), 32'd0);
      checkOutput("t7_overflow", 32'(overflow), 32'd0);
      leaveTest();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
